// File: rtl/plle2_seq_pkg.sv
// Shared definitions for the PLLE2 lock sequencer: state encoding and the
// width of the lock-loss statistics counter.
package plle2_seq_pkg;

  typedef enum logic [1:0] {
    ST_RESET     = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RUN       = 2'd2,
    ST_FAIL      = 2'd3
  } state_e;

  localparam int RELOCK_W = 8;

endpackage

// File: rtl/plle2_lock_seq_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the CLK domain.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/plle2_lock_seq.sv
// PLL reset / input-select sequencer with LOCKED debouncing and bounded retry.
// Define PLLE2_LOCK_SEQ_STATS_EN to implement the lock-loss counter O_RELOCK_CNT.
module plle2_lock_seq
  import plle2_seq_pkg::*;
#(
  parameter int RST_CYCLES   = 64,
  parameter int LOCK_FILTER  = 16,
  parameter int LOCK_TIMEOUT = 1000000,
  parameter int MAX_RETRY    = 3
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                I_CLKINSEL,
  input  logic                I_LOCKED,
  output logic                O_PLL_RST,
  output logic                O_CLKINSEL,
  output logic                O_READY,
  output logic                O_FAIL,
  output logic [1:0]          O_STATE,
  output logic [RELOCK_W-1:0] O_RELOCK_CNT
);

  localparam int RST_W   = $clog2(RST_CYCLES + 1);
  localparam int FILT_W  = $clog2(LOCK_FILTER + 1);
  localparam int TO_W    = $clog2(LOCK_TIMEOUT + 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  localparam logic [RST_W-1:0]   RST_LAST   = RST_W'(RST_CYCLES - 1);
  localparam logic [FILT_W-1:0]  FILT_LAST  = FILT_W'(LOCK_FILTER - 1);
  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);

  logic sel_s;
  logic lock_s;

  sync_2ff u_sync_sel (
    .clk_i  (CLK),
    .rst_ni (RSTN),
    .d_i    (I_CLKINSEL),
    .q_o    (sel_s)
  );

  sync_2ff u_sync_lock (
    .clk_i  (CLK),
    .rst_ni (RSTN),
    .d_i    (I_LOCKED),
    .q_o    (lock_s)
  );

  state_e               state_q;
  logic [RST_W-1:0]     rst_cnt_q;
  logic [FILT_W-1:0]    filt_q;
  logic [TO_W-1:0]      to_cnt_q;
  logic [RETRY_W-1:0]   retry_q;
  logic                 pll_rst_q;
  logic                 clkinsel_q;
  logic                 ready_q;
  logic                 fail_q;
  logic                 sel_chg;

  // Inside RESET a differing select only restarts the pulse, handled in the FSM.
  assign sel_chg = (state_q != ST_RESET) && (sel_s != clkinsel_q);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= ST_RESET;
      rst_cnt_q  <= '0;
      filt_q     <= '0;
      to_cnt_q   <= '0;
      retry_q    <= '0;
      pll_rst_q  <= 1'b1;
      clkinsel_q <= 1'b0;
      ready_q    <= 1'b0;
      fail_q     <= 1'b0;
    end else if (sel_chg) begin
      state_q    <= ST_RESET;
      rst_cnt_q  <= '0;
      retry_q    <= '0;
      pll_rst_q  <= 1'b1;
      clkinsel_q <= sel_s;
      ready_q    <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (sel_s != clkinsel_q) begin
            clkinsel_q <= sel_s;
            rst_cnt_q  <= '0;
          end else if (rst_cnt_q == RST_LAST) begin
            state_q   <= ST_WAIT_LOCK;
            pll_rst_q <= 1'b0;
            rst_cnt_q <= '0;
            filt_q    <= '0;
            to_cnt_q  <= '0;
          end else begin
            rst_cnt_q <= rst_cnt_q + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          to_cnt_q <= to_cnt_q + 1'b1;
          filt_q   <= lock_s ? filt_q + 1'b1 : '0;
          // Filter completion takes priority over a coincident timeout.
          if (lock_s && (filt_q == FILT_LAST)) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
            retry_q <= '0;
          end else if (to_cnt_q == TO_LAST) begin
            retry_q   <= retry_q + 1'b1;
            pll_rst_q <= 1'b1;
            rst_cnt_q <= '0;
            if (retry_q == RETRY_LAST) begin
              state_q <= ST_FAIL;
              fail_q  <= 1'b1;
            end else begin
              state_q <= ST_RESET;
            end
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_q   <= ST_RESET;
            ready_q   <= 1'b0;
            pll_rst_q <= 1'b1;
            rst_cnt_q <= '0;
          end
        end
        ST_FAIL: begin
          pll_rst_q <= 1'b1;
          fail_q    <= 1'b1;
        end
        default: state_q <= ST_RESET;
      endcase
    end
  end

  assign O_PLL_RST  = pll_rst_q;
  assign O_CLKINSEL = clkinsel_q;
  assign O_READY    = ready_q;
  assign O_FAIL     = fail_q;
  assign O_STATE    = state_q;

`ifdef PLLE2_LOCK_SEQ_STATS_EN
  logic                lock_loss;
  logic [RELOCK_W-1:0] relock_q;
  logic [RELOCK_W-1:0] relock_d;

  // A select change in the same cycle is a deliberate switch, not a lock loss.
  assign lock_loss = (state_q == ST_RUN) && (sel_s == clkinsel_q) && !lock_s;

  always_comb begin
    relock_d = relock_q;
    if (lock_loss && (relock_q != {RELOCK_W{1'b1}})) begin
      relock_d = relock_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      relock_q <= '0;
    end else begin
      relock_q <= relock_d;
    end
  end

  assign O_RELOCK_CNT = relock_q;
`else
  assign O_RELOCK_CNT = '0;
`endif

endmodule

// File: tb/tb_plle2_lock_seq.sv
// Directed self-checking bench for plle2_lock_seq with small timing parameters.
module tb_plle2_lock_seq;
  import plle2_seq_pkg::*;

`ifdef PLLE2_LOCK_SEQ_STATS_EN
  localparam int RELOCK_STEP = 1;
`else
  localparam int RELOCK_STEP = 0;
`endif

  logic                CLK;
  logic                RSTN;
  logic                I_CLKINSEL;
  logic                I_LOCKED;
  logic                O_PLL_RST;
  logic                O_CLKINSEL;
  logic                O_READY;
  logic                O_FAIL;
  logic [1:0]          O_STATE;
  logic [RELOCK_W-1:0] O_RELOCK_CNT;

  int passed = 0;
  int total  = 0;

  plle2_lock_seq #(
    .RST_CYCLES   (8),
    .LOCK_FILTER  (4),
    .LOCK_TIMEOUT (100),
    .MAX_RETRY    (2)
  ) dut (
    .CLK          (CLK),
    .RSTN         (RSTN),
    .I_CLKINSEL   (I_CLKINSEL),
    .I_LOCKED     (I_LOCKED),
    .O_PLL_RST    (O_PLL_RST),
    .O_CLKINSEL   (O_CLKINSEL),
    .O_READY      (O_READY),
    .O_FAIL       (O_FAIL),
    .O_STATE      (O_STATE),
    .O_RELOCK_CNT (O_RELOCK_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Counts consecutive negedge samples at which O_PLL_RST equals lvl, starting now.
  task automatic measure_rst(input logic lvl, output int n);
    n = 0;
    while (O_PLL_RST === lvl && n < 300) begin
      n++;
      @(negedge CLK);
    end
  endtask

  // Counts negedges until O_READY reaches lvl, bounded.
  task automatic wait_ready(input logic lvl, output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (O_READY !== lvl && n < 40);
  endtask

  task automatic test_reset;
    RSTN = 1'b0; I_CLKINSEL = 1'b0; I_LOCKED = 1'b0;
    repeat (3) @(negedge CLK);
    total++; if (O_PLL_RST !== 1'b1) $display("[TB] FAIL rst_pll_rst got %0d want 1", O_PLL_RST); else passed++;
    total++; if (O_CLKINSEL !== 1'b0) $display("[TB] FAIL rst_clkinsel got %0d want 0", O_CLKINSEL); else passed++;
    total++; if (O_READY !== 1'b0) $display("[TB] FAIL rst_ready got %0d want 0", O_READY); else passed++;
    total++; if (O_FAIL !== 1'b0) $display("[TB] FAIL rst_fail got %0d want 0", O_FAIL); else passed++;
    total++; if (O_STATE !== 2'd0) $display("[TB] FAIL rst_state got %0d want 0", O_STATE); else passed++;
    total++; if (O_RELOCK_CNT !== 8'd0) $display("[TB] FAIL rst_relock got %0d want 0", O_RELOCK_CNT); else passed++;
  endtask

  task automatic test_power_up;
    int n;
    RSTN = 1'b1;
    measure_rst(1'b1, n);
    total++; if (n != 8) $display("[TB] FAIL pwr_rst_width got %0d want 8", n); else passed++;
    repeat (12) @(negedge CLK);
    I_LOCKED = 1'b1;
    wait_ready(1'b1, n);
    total++; if (n != 6) $display("[TB] FAIL pwr_ready_latency got %0d want 6", n); else passed++;
    total++; if (O_STATE !== 2'd2) $display("[TB] FAIL pwr_state got %0d want 2", O_STATE); else passed++;
  endtask

  task automatic test_lock_loss;
    int n;
    n = 0;
    I_LOCKED = 1'b0;
    do begin
      @(negedge CLK);
      n++;
      if (n == 1) I_LOCKED = 1'b1;
    end while (O_READY !== 1'b0 && n < 20);
    total++; if (n != 3) $display("[TB] FAIL loss_ready_drop got %0d want 3", n); else passed++;
    measure_rst(1'b1, n);
    total++; if (n != 8) $display("[TB] FAIL loss_rst_width got %0d want 8", n); else passed++;
    wait_ready(1'b1, n);
    total++; if (n != 4) $display("[TB] FAIL loss_relock_latency got %0d want 4", n); else passed++;
    total++; if (O_RELOCK_CNT !== 8'(RELOCK_STEP)) $display("[TB] FAIL loss_relock_cnt got %0d want %0d", O_RELOCK_CNT, RELOCK_STEP); else passed++;
  endtask

  task automatic test_glitchy_lock;
    int n;
    logic early_ready;
    I_LOCKED = 1'b0;
    n = 0;
    while (O_PLL_RST !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    measure_rst(1'b1, n);
    early_ready = 1'b0;
    I_LOCKED = 1'b1;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
      if (n == 3) I_LOCKED = 1'b0;
      if (n == 4) I_LOCKED = 1'b1;
      if (n == 6) early_ready = O_READY;
    end while (O_READY !== 1'b1 && n < 40);
    total++; if (early_ready !== 1'b0) $display("[TB] FAIL glitch_early_ready got %0d want 0", early_ready); else passed++;
    total++; if (n != 10) $display("[TB] FAIL glitch_ready_latency got %0d want 10", n); else passed++;
    total++; if (O_RELOCK_CNT !== 8'(2 * RELOCK_STEP)) $display("[TB] FAIL glitch_relock_cnt got %0d want %0d", O_RELOCK_CNT, 2 * RELOCK_STEP); else passed++;
  endtask

  task automatic test_source_switch;
    int n;
    I_CLKINSEL = 1'b1;
    repeat (2) @(negedge CLK);
    total++; if (O_CLKINSEL !== 1'b0 || O_PLL_RST !== 1'b0) $display("[TB] FAIL sw_before sel=%0d rst=%0d want 0 0", O_CLKINSEL, O_PLL_RST); else passed++;
    @(negedge CLK);
    total++; if (O_CLKINSEL !== 1'b1 || O_PLL_RST !== 1'b1) $display("[TB] FAIL sw_after sel=%0d rst=%0d want 1 1", O_CLKINSEL, O_PLL_RST); else passed++;
    total++; if (O_READY !== 1'b0 || O_STATE !== 2'd0) $display("[TB] FAIL sw_ready_state ready=%0d state=%0d want 0 0", O_READY, O_STATE); else passed++;
    measure_rst(1'b1, n);
    total++; if (n != 8) $display("[TB] FAIL sw_rst_width got %0d want 8", n); else passed++;
    wait_ready(1'b1, n);
    total++; if (n != 4) $display("[TB] FAIL sw_relock_latency got %0d want 4", n); else passed++;
    total++; if (O_CLKINSEL !== 1'b1) $display("[TB] FAIL sw_sel_hold got %0d want 1", O_CLKINSEL); else passed++;
    total++; if (O_RELOCK_CNT !== 8'(2 * RELOCK_STEP)) $display("[TB] FAIL sw_relock_cnt got %0d want %0d", O_RELOCK_CNT, 2 * RELOCK_STEP); else passed++;
  endtask

  task automatic test_timeout_fail;
    int n;
    RSTN = 1'b0; I_CLKINSEL = 1'b0; I_LOCKED = 1'b0;
    repeat (3) @(negedge CLK);
    total++; if (O_CLKINSEL !== 1'b0 || O_READY !== 1'b0 || O_STATE !== 2'd0) $display("[TB] FAIL to_reset sel=%0d ready=%0d state=%0d want 0 0 0", O_CLKINSEL, O_READY, O_STATE); else passed++;
    total++; if (O_RELOCK_CNT !== 8'd0) $display("[TB] FAIL to_reset_relock got %0d want 0", O_RELOCK_CNT); else passed++;
    RSTN = 1'b1;
    measure_rst(1'b1, n);
    total++; if (n != 8) $display("[TB] FAIL to_rst1_width got %0d want 8", n); else passed++;
    measure_rst(1'b0, n);
    total++; if (n != 100) $display("[TB] FAIL to_wait1_len got %0d want 100", n); else passed++;
    total++; if (O_STATE !== 2'd0 || O_FAIL !== 1'b0) $display("[TB] FAIL to_retry_state state=%0d fail=%0d want 0 0", O_STATE, O_FAIL); else passed++;
    measure_rst(1'b1, n);
    total++; if (n != 8) $display("[TB] FAIL to_rst2_width got %0d want 8", n); else passed++;
    measure_rst(1'b0, n);
    total++; if (n != 100) $display("[TB] FAIL to_wait2_len got %0d want 100", n); else passed++;
    total++; if (O_FAIL !== 1'b1) $display("[TB] FAIL to_fail_flag got %0d want 1", O_FAIL); else passed++;
    total++; if (O_STATE !== 2'd3) $display("[TB] FAIL to_fail_state got %0d want 3", O_STATE); else passed++;
    total++; if (O_PLL_RST !== 1'b1) $display("[TB] FAIL to_fail_pll_rst got %0d want 1", O_PLL_RST); else passed++;
  endtask

  task automatic test_fail_recovery;
    int n;
    I_LOCKED   = 1'b1;
    I_CLKINSEL = 1'b1;
    repeat (2) @(negedge CLK);
    total++; if (O_STATE !== 2'd3) $display("[TB] FAIL rec_still_fail got %0d want 3", O_STATE); else passed++;
    @(negedge CLK);
    total++; if (O_FAIL !== 1'b0 || O_STATE !== 2'd0) $display("[TB] FAIL rec_exit fail=%0d state=%0d want 0 0", O_FAIL, O_STATE); else passed++;
    total++; if (O_CLKINSEL !== 1'b1) $display("[TB] FAIL rec_sel got %0d want 1", O_CLKINSEL); else passed++;
    wait_ready(1'b1, n);
    total++; if (O_READY !== 1'b1 || O_STATE !== 2'd2) $display("[TB] FAIL rec_ready ready=%0d state=%0d want 1 2", O_READY, O_STATE); else passed++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    RSTN = 1'b0; I_CLKINSEL = 1'b0; I_LOCKED = 1'b0;
    test_reset();
    test_power_up();
    test_lock_loss();
    test_glitchy_lock();
    test_source_switch();
    test_timeout_fail();
    test_fail_recovery();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
